// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface bus_rr_arbiter_if #(
    parameter int unsigned CHANNEL = 2
);
    localparam int unsigned ID_W = ($clog2(CHANNEL) > 0) ? $clog2(CHANNEL) : 1;

    logic [CHANNEL-1:0] req;
    logic               done;
    logic [CHANNEL-1:0] grant;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               timeout_err;

    // Requester side drives requests and completion, observes the grant.
    modport master (
        output req, done,
        input  grant, grant_valid, grant_id, timeout_err
    );

    // Arbiter side.
    modport slave (
        input  req, done,
        output grant, grant_valid, grant_id, timeout_err
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter with transaction lock and optional hung-grant watchdog.
// The grant is a registered one-hot select for the downstream bus mux.
module bus_rr_arbiter #(
    parameter int unsigned CHANNEL = 2,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    bus_rr_arbiter_if.slave bus
);
    localparam int unsigned ID_W  = ($clog2(CHANNEL) > 0) ? $clog2(CHANNEL) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(CHANNEL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt;

    logic [CHANNEL-1:0] masked;
    logic [CHANNEL-1:0] cand;
    logic [ID_W-1:0]    win_id;
    logic [CHANNEL-1:0] win_oh;
    logic [ID_W-1:0]    ptr_next;
    logic               expire;
    logic               release_now;

    // Winner search: requests at or above ptr take precedence, else wrap to the lowest set bit.
    always_comb begin
        masked   = '0;
        cand     = '0;
        win_id   = '0;
        for (int i = 0; i < int'(CHANNEL); i++) begin
            masked[i] = bus.req[i] && (i >= int'(ptr));
        end
        cand = (|masked) ? masked : bus.req;
        for (int i = int'(CHANNEL) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = ID_W'(i);
            end
        end
        win_oh   = CHANNEL'(1) << win_id;
        ptr_next = (win_id == ID_LAST) ? '0 : win_id + ID_W'(1);
    end

    // Watchdog expiry acts like done; a real done at the same edge takes precedence.
    always_comb begin
        expire      = (TIMEOUT != 0) && (state == BUSY) && !bus.done && (cnt == CNT_LAST);
        release_now = (state == BUSY) && (bus.done || expire);
    end

    // Grant FSM: lock the owner until release, then re-arbitrate back-to-back or drop to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            cnt             <= '0;
            bus.grant       <= '0;
            bus.grant_valid <= 1'b0;
            bus.grant_id    <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state           <= BUSY;
                        bus.grant       <= win_oh;
                        bus.grant_valid <= 1'b1;
                        bus.grant_id    <= win_id;
                        ptr             <= ptr_next;
                        cnt             <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        bus.timeout_err <= expire;
                        cnt             <= '0;
                        if (|bus.req) begin
                            bus.grant       <= win_oh;
                            bus.grant_valid <= 1'b1;
                            bus.grant_id    <= win_id;
                            ptr             <= ptr_next;
                        end else begin
                            state           <= IDLE;
                            bus.grant       <= '0;
                            bus.grant_valid <= 1'b0;
                            bus.grant_id    <= '0;
                        end
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed vector table, watchdog sequence, and
// random traffic against a queue-free behavioural model of the arbitration rules.
module tb_bus_rr_arbiter;
    localparam int C = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    bus_rr_arbiter_if #(.CHANNEL(C)) bus0 ();
    bus_rr_arbiter_if #(.CHANNEL(C)) bus1 ();

    bus_rr_arbiter #(.CHANNEL(C), .TIMEOUT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    bus_rr_arbiter #(.CHANNEL(C), .TIMEOUT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic       done;
        logic [2:0] g;
        int         id;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state per DUT (index 0: no watchdog, 1: TIMEOUT=4).
    int         to_val [2] = '{0, 4};
    int         m_owner[2];
    int         m_ptr  [2];
    int         m_age  [2];
    logic       m_te   [2];
    logic       m_arb  [2];
    logic [2:0] m_arbreq[2];
    int         waitc  [2][C];
    logic       prev_te[2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] q, input logic d,
                       input logic [2:0] g, input int id);
        vec_t v;
        v.rst = r; v.req = q; v.done = d; v.g = g; v.id = id;
        tbl.push_back(v);
    endtask

    task automatic rd(input int d, output logic [2:0] g, output int id,
                      output logic v, output logic te);
        if (d == 0) begin
            g = bus0.grant; id = int'(bus0.grant_id); v = bus0.grant_valid; te = bus0.timeout_err;
        end else begin
            g = bus1.grant; id = int'(bus1.grant_id); v = bus1.grant_valid; te = bus1.timeout_err;
        end
    endtask

    // Model: scan upward from ptr with wrap, first requester wins.
    task automatic m_grant(input int d, input logic [2:0] q);
        int w;
        w = -1;
        for (int k = 0; k < C; k++) begin
            int idx;
            idx = (m_ptr[d] + k) % C;
            if (q[idx] && w < 0) w = idx;
        end
        m_owner[d]  = w;
        m_ptr[d]    = (w + 1) % C;
        m_age[d]    = 0;
        m_arb[d]    = 1'b1;
        m_arbreq[d] = q;
    endtask

    task automatic model_step(input int d, input logic r, input logic [2:0] q, input logic dn);
        logic exp_now;
        m_arb[d] = 1'b0;
        if (r) begin
            m_owner[d] = -1; m_ptr[d] = 0; m_age[d] = 0; m_te[d] = 1'b0;
            for (int i = 0; i < C; i++) waitc[d][i] = 0;
            return;
        end
        m_te[d] = 1'b0;
        if (m_owner[d] < 0) begin
            if (q != 3'b000) m_grant(d, q);
        end else begin
            exp_now = 1'b0;
            if (!dn && to_val[d] > 0) begin
                m_age[d]++;
                if (m_age[d] == to_val[d]) exp_now = 1'b1;
            end
            if (dn || exp_now) begin
                m_te[d] = exp_now;
                if (q != 3'b000) m_grant(d, q);
                else m_owner[d] = -1;
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, settle 1 time unit after it.
    task automatic cyc(input logic r, input logic [2:0] q, input logic dn);
        rst = r;
        bus0.req = q; bus0.done = dn;
        bus1.req = q; bus1.done = dn;
        @(posedge clk);
        model_step(0, r, q, dn);
        model_step(1, r, q, dn);
        #1;
    endtask

    task automatic chk1(input string name, input logic [2:0] eg, input int eid, input logic ete);
        logic [2:0] g; int id; logic v; logic te;
        rd(1, g, id, v, te);
        chk({name, ".grant"}, int'(g), int'(eg));
        chk({name, ".id"}, id, eid);
        chk({name, ".terr"}, int'(te), int'(ete));
    endtask

    initial begin
        logic [2:0] g; int id; logic v; logic te;
        bus0.req = '0; bus0.done = 1'b0;
        bus1.req = '0; bus1.done = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_ptr[d] = 0; m_age[d] = 0; m_te[d] = 1'b0;
            m_arb[d] = 1'b0; m_arbreq[d] = '0; prev_te[d] = 1'b0;
            for (int i = 0; i < C; i++) waitc[d][i] = 0;
        end

        // Reset, single request, owner dropping req, done release, spurious done.
        add(1, 3'b000, 0, 3'b000, 0);
        add(0, 3'b010, 0, 3'b010, 1);
        add(0, 3'b010, 0, 3'b010, 1);
        add(0, 3'b000, 0, 3'b010, 1);
        add(0, 3'b000, 0, 3'b010, 1);
        add(0, 3'b000, 1, 3'b000, 0);
        add(0, 3'b000, 1, 3'b000, 0);
        add(0, 3'b000, 1, 3'b000, 0);
        // Rotation with all requesting, back-to-back.
        add(1, 3'b111, 0, 3'b000, 0);
        add(0, 3'b111, 0, 3'b001, 0);
        add(0, 3'b111, 0, 3'b001, 0);
        add(0, 3'b111, 0, 3'b001, 0);
        add(0, 3'b111, 1, 3'b010, 1);
        add(0, 3'b111, 0, 3'b010, 1);
        add(0, 3'b111, 0, 3'b010, 1);
        add(0, 3'b111, 1, 3'b100, 2);
        add(0, 3'b111, 0, 3'b100, 2);
        add(0, 3'b111, 0, 3'b100, 2);
        add(0, 3'b111, 1, 3'b001, 0);
        // Lock hold while req changes.
        add(0, 3'b110, 0, 3'b001, 0);
        add(0, 3'b111, 0, 3'b001, 0);
        add(0, 3'b110, 0, 3'b001, 0);
        add(0, 3'b001, 0, 3'b001, 0);
        add(0, 3'b110, 1, 3'b010, 1);
        // Mid-transaction resets restore ptr to 0.
        add(0, 3'b100, 1, 3'b100, 2);
        add(0, 3'b111, 0, 3'b100, 2);
        add(1, 3'b111, 0, 3'b000, 0);
        add(0, 3'b111, 0, 3'b001, 0);
        add(0, 3'b010, 1, 3'b010, 1);
        add(1, 3'b111, 1, 3'b000, 0);
        add(0, 3'b111, 0, 3'b001, 0);
        // Owner alone re-wins back-to-back, then release.
        add(0, 3'b001, 1, 3'b001, 0);
        add(0, 3'b000, 1, 3'b000, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].rst, tbl[k].req, tbl[k].done);
            rd(0, g, id, v, te);
            chk($sformatf("vec%0d.grant", k), int'(g), int'(tbl[k].g));
            chk($sformatf("vec%0d.id", k), id, tbl[k].id);
            chk($sformatf("vec%0d.valid", k), int'(v), int'(tbl[k].g != 3'b000));
            chk($sformatf("vec%0d.terr", k), int'(te), 0);
        end

        // Watchdog on the TIMEOUT=4 instance.
        cyc(1, 3'b000, 0); chk1("wd_rst", 3'b000, 0, 0);
        cyc(0, 3'b100, 0); chk1("wd_grant", 3'b100, 2, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 3'b011, 0); chk1("wd_hold", 3'b100, 2, 0);
        end
        cyc(0, 3'b011, 0); chk1("wd_expire_regrant", 3'b001, 0, 1);
        cyc(0, 3'b000, 0); chk1("wd_pulse_end", 3'b001, 0, 0);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 3'b000, 0); chk1("wd_hold2", 3'b001, 0, 0);
        end
        cyc(0, 3'b000, 0); chk1("wd_expire_idle", 3'b000, 0, 1);
        cyc(0, 3'b000, 0); chk1("wd_idle", 3'b000, 0, 0);
        cyc(0, 3'b001, 0); chk1("wd_grant3", 3'b001, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 3'b001, 0); chk1("wd_hold3", 3'b001, 0, 0);
        end
        cyc(0, 3'b000, 1); chk1("wd_done_wins", 3'b000, 0, 0);
        cyc(0, 3'b000, 0); chk1("wd_after_done", 3'b000, 0, 0);

        // Random traffic against the model, with invariant and starvation checks.
        cyc(1, 3'b000, 0);
        for (int d = 0; d < 2; d++) prev_te[d] = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            logic       r;
            logic [2:0] q;
            logic       dn;
            r  = ($urandom % 300) == 0;
            q  = 3'($urandom % 8);
            dn = ($urandom % 4) == 0;
            cyc(r, q, dn);
            for (int d = 0; d < 2; d++) begin
                int eid;
                rd(d, g, id, v, te);
                eid = (m_owner[d] < 0) ? 0 : m_owner[d];
                chk($sformatf("rnd%0d.d%0d.grant", n, d), int'(g),
                    (m_owner[d] < 0) ? 0 : (1 << m_owner[d]));
                chk($sformatf("rnd%0d.d%0d.id", n, d), id, eid);
                chk($sformatf("rnd%0d.d%0d.terr", n, d), int'(te), int'(m_te[d]));
                chk($sformatf("rnd%0d.d%0d.onehot0", n, d), int'($onehot0(g)), 1);
                chk($sformatf("rnd%0d.d%0d.valid_or", n, d), int'(v), int'(|g));
                chk($sformatf("rnd%0d.d%0d.id_pos", n, d), int'(g),
                    (g == 3'b000) ? 0 : (1 << id));
                chk($sformatf("rnd%0d.d%0d.terr_twice", n, d), int'(prev_te[d] && te), 0);
                prev_te[d] = te;
                if (r) begin
                    for (int i = 0; i < C; i++) waitc[d][i] = 0;
                end else if (m_arb[d]) begin
                    for (int i = 0; i < C; i++) begin
                        if (m_arbreq[d][i] && !(v && id == i)) waitc[d][i]++;
                        else waitc[d][i] = 0;
                        chk($sformatf("rnd%0d.d%0d.starve%0d", n, d, i), int'(waitc[d][i] < C), 1);
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
